// File: rtl/fifo_uart_tx.sv
// ============================================================================
// Module   : fifo_uart_tx
// Purpose  : Pops words from the async FIFO read side and sends UART frames.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module fifo_uart_tx #(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 6
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      empty,
  input  logic [DATA_WIDTH-1:0]     rd_data,
  output logic                      r_inc,
  input  logic                      tx_en,
  input  logic [PRESCALE_WIDTH-1:0] prescale,
  input  logic                      par_en,
  input  logic                      par_typ,
  output logic                      tx_out,
  output logic                      busy
);

  localparam int c_BIT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t                    r_state;
  logic [DATA_WIDTH-1:0]     r_shift;
  logic [c_BIT_W-1:0]        r_bit_cnt;
  logic [PRESCALE_WIDTH-1:0] r_cnt;
  logic [PRESCALE_WIDTH-1:0] r_pmax;
  logic                      r_par_en;
  logic                      r_par_bit;
  logic                      r_tx_out;
  logic                      r_busy;

  logic                      w_last;
  logic                      w_pop;
  logic [PRESCALE_WIDTH-1:0] w_pmax_in;
  logic [DATA_WIDTH-1:0]     w_shift_nxt;

  assign w_last      = (r_cnt == r_pmax);
  assign w_pop       = tx_en & ~empty & ((r_state == S_IDLE) | ((r_state == S_STOP) & w_last));
  // Reset gates the strobe so the FIFO never sees a pop while we are held in reset.
  assign r_inc       = w_pop & rst_n;
  assign w_pmax_in   = (prescale == '0) ? '0 : prescale - PRESCALE_WIDTH'(1);
  assign w_shift_nxt = r_shift >> 1;
  assign tx_out      = r_tx_out;
  assign busy        = r_busy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= S_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_cnt     <= '0;
      r_pmax    <= '0;
      r_par_en  <= 1'b0;
      r_par_bit <= 1'b0;
      r_tx_out  <= 1'b1;
      r_busy    <= 1'b0;
    end else if (w_pop) begin
      r_state   <= S_START;
      r_shift   <= rd_data;
      r_bit_cnt <= '0;
      r_cnt     <= '0;
      r_pmax    <= w_pmax_in;
      r_par_en  <= par_en;
      r_par_bit <= (^rd_data) ^ par_typ;
      r_tx_out  <= 1'b0;
      r_busy    <= 1'b1;
    end else begin
      if (r_state != S_IDLE) begin
        r_cnt <= w_last ? '0 : r_cnt + PRESCALE_WIDTH'(1);
      end
      case (r_state)
        S_IDLE: begin
          r_tx_out <= 1'b1;
          r_busy   <= 1'b0;
        end
        S_START: begin
          if (w_last) begin
            r_state  <= S_DATA;
            r_tx_out <= r_shift[0];
          end
        end
        S_DATA: begin
          if (w_last) begin
            if (r_bit_cnt == c_BIT_W'(DATA_WIDTH - 1)) begin
              r_state  <= r_par_en ? S_PARITY : S_STOP;
              r_tx_out <= r_par_en ? r_par_bit : 1'b1;
            end else begin
              r_bit_cnt <= r_bit_cnt + c_BIT_W'(1);
              r_shift   <= w_shift_nxt;
              r_tx_out  <= w_shift_nxt[0];
            end
          end
        end
        S_PARITY: begin
          if (w_last) begin
            r_state  <= S_STOP;
            r_tx_out <= 1'b1;
          end
        end
        S_STOP: begin
          // A pop in the final stop cycle is handled above and chains frames.
          if (w_last) begin
            r_state  <= S_IDLE;
            r_tx_out <= 1'b1;
            r_busy   <= 1'b0;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_tx_out <= 1'b1;
          r_busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
// ============================================================================
// Module   : tb_fifo_uart_tx
// Purpose  : Directed self-checking bench for fifo_uart_tx with a FIFO model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_fifo_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       empty;
  logic [7:0] rd_data;
  logic       r_inc;
  logic       tx_en;
  logic [5:0] prescale;
  logic       par_en;
  logic       par_typ;
  logic       tx_out;
  logic       busy;

  logic [7:0] fifo_mem [16];
  logic [3:0] wr_ptr = 4'd0;
  logic [3:0] rd_ptr = 4'd0;
  int         pops      = 0;
  int         bad_pops  = 0;
  int         n_cmp     = 0;
  int         n_err     = 0;

  always #5 clk = ~clk;

  assign empty   = (wr_ptr == rd_ptr);
  assign rd_data = fifo_mem[rd_ptr];

  always @(posedge clk) begin
    if (r_inc) begin
      if (empty) bad_pops <= bad_pops + 1;
      else       rd_ptr   <= rd_ptr + 4'd1;
      pops <= pops + 1;
    end
  end

  fifo_uart_tx #(.DATA_WIDTH(8), .PRESCALE_WIDTH(6)) dut (
    .clk(clk), .rst_n(rst_n), .empty(empty), .rd_data(rd_data), .r_inc(r_inc),
    .tx_en(tx_en), .prescale(prescale), .par_en(par_en), .par_typ(par_typ),
    .tx_out(tx_out), .busy(busy)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    fifo_mem[wr_ptr] = d;
    wr_ptr = wr_ptr + 4'd1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_busy(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (busy) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // action: 0 none, 1 drop tx_en at frame start, 2 change prescale at frame start
  task automatic capture(input string tag, input logic [63:0] exp_bits, input int exp_len,
                         input int p, input int exp_inc, input int action);
    bit          ok;
    logic [63:0] obs;
    int          c, bitn, glitch, inc_cnt, inc_cyc;
    wait_busy(ok);
    if (!ok) begin
      check({tag, "_start"}, 64'd0, 64'd1);
      return;
    end
    if (action == 1) tx_en = 1'b0;
    if (action == 2) prescale = 6'd7;
    obs = '0; c = 0; glitch = 0; inc_cnt = 0; inc_cyc = -1;
    while (busy && c < 1000) begin
      bitn = c / p;
      if (r_inc) begin
        inc_cnt++;
        inc_cyc = c;
      end
      if (bitn < 64) begin
        if (c % p == 0) obs[bitn] = tx_out;
        else if (tx_out !== obs[bitn]) glitch++;
      end
      c++;
      tick();
    end
    check({tag, "_bits"}, obs, exp_bits);
    check({tag, "_len"}, 64'(c), 64'(exp_len));
    check({tag, "_glitch"}, 64'(glitch), 64'd0);
    if (exp_inc >= 0) check({tag, "_inc_cyc"}, 64'(inc_cyc), 64'(exp_inc));
    else              check({tag, "_inc_cnt"}, 64'(inc_cnt), 64'd0);
  endtask

  initial begin
    rst_n    = 1'b0;
    tx_en    = 1'b1;
    prescale = 6'd4;
    par_en   = 1'b0;
    par_typ  = 1'b0;
    push(8'hA5);

    // Held in reset with data available: idle line, no pop.
    for (int i = 0; i < 3; i++) begin
      tick();
      check("rst_outs", {61'd0, tx_out, busy, r_inc}, 64'b100);
    end
    rst_n = 1'b1;
    #1;
    check("pop_after_rst", 64'(r_inc), 64'd1);
    capture("a5_nopar", 64'h34A, 40, 4, -1, 0);
    check("pops_1", 64'(pops), 64'd1);

    par_en = 1'b1; par_typ = 1'b0; push(8'hA5);
    capture("a5_even", 64'h54A, 44, 4, -1, 0);
    par_typ = 1'b1; push(8'hA5);
    capture("a5_odd", 64'h74A, 44, 4, -1, 0);
    par_typ = 1'b0; push(8'h01);
    capture("01_even", 64'h602, 44, 4, -1, 0);
    check("pops_4", 64'(pops), 64'd4);

    // Back-to-back: second pop lands in the last stop cycle of frame 1.
    par_en = 1'b0; prescale = 6'd2;
    push(8'h3C); push(8'hC3);
    capture("b2b", 64'hE1A78, 40, 2, 19, 0);
    check("pops_6", 64'(pops), 64'd6);

    prescale = 6'd0; push(8'h5A);
    capture("ps0", 64'h2B4, 10, 1, -1, 0);

    prescale = 6'd2; push(8'h11); push(8'h22);
    capture("txen_drop", 64'h222, 20, 2, -1, 1);
    repeat (30) tick();
    check("idle_busy", 64'(busy), 64'd0);
    check("idle_line", 64'(tx_out), 64'd1);
    check("pops_8", 64'(pops), 64'd8);
    tx_en = 1'b1;
    #1;
    check("txen_repop", 64'(r_inc), 64'd1);
    capture("txen_word2", 64'h244, 20, 2, -1, 0);

    prescale = 6'd3; push(8'h96);
    capture("ps_change", 64'h32C, 30, 3, -1, 2);
    check("pops_10", 64'(pops), 64'd10);

    // Reset during data bit 3 (cycles 16..19 at P=4).
    prescale = 6'd4; push(8'hF0); push(8'h0F);
    begin
      bit ok;
      wait_busy(ok);
      check("rst_mid_start", 64'(ok), 64'd1);
    end
    repeat (17) tick();
    rst_n = 1'b0;
    #1;
    check("rst_mid_outs", {61'd0, tx_out, busy, r_inc}, 64'b100);
    repeat (2) tick();
    check("rst_hold_outs", {61'd0, tx_out, busy, r_inc}, 64'b100);
    rst_n = 1'b1;
    #1;
    check("rst_mid_repop", 64'(r_inc), 64'd1);
    capture("after_rst", 64'h21E, 40, 4, -1, 0);
    check("pops_12", 64'(pops), 64'd12);
    check("bad_pops", 64'(bad_pops), 64'd0);
    check("fifo_drained", 64'(empty), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fifo_uart_tx.md
Name: fifo_uart_tx

Overview:
- Read-side consumer of the async FIFO, running in the read-clock domain.
- Pops one word whenever the FIFO is non-empty and the transmitter is free, then serialises it as a UART frame.
- Frame format: start bit, DATA_WIDTH data bits LSB first, optional parity bit, one stop bit.
- Drives the FIFO read-increment and the serial line directly; there is no external pulse generator.

Parameters:
- DATA_WIDTH, 8, width of the FIFO word and of the frame data field.
- PRESCALE_WIDTH, 6, width of the PRESCALE input (clock cycles per bit).

Ports:
- CLK  input  1  read-domain clock; all logic is on the rising edge.
- RST  input  1  asynchronous active-low reset.
- EMPTY  input  1  FIFO empty flag, already synchronous to CLK.
- RD_DATA  input  DATA_WIDTH  FIFO read data; combinationally valid while EMPTY=0.
- R_INC  output  1  FIFO pop strobe; exactly one CLK cycle per word.
- TX_EN  input  1  permits new frames; never aborts a frame in progress.
- PRESCALE  input  PRESCALE_WIDTH  clock cycles per bit; 0 is treated as 1.
- PAR_EN  input  1  1 = append a parity bit.
- PAR_TYP  input  1  0 = even parity, 1 = odd parity.
- TX_OUT  output  1  serial line; idles high.
- BUSY  output  1  high while a frame is in progress.

Behaviour:
- Reset (RST=0, asynchronous):
  - state=IDLE, TX_OUT=1, BUSY=0, R_INC=0.
  - Shift register, bit counter and prescale counter cleared.
- Pop condition: pop = TX_EN & ~EMPTY & (state==IDLE | last cycle of STOP).
  - R_INC = pop, combinational.
  - On the same edge: RD_DATA is latched into the shift register, and PAR_EN, PAR_TYP and PRESCALE are latched for the whole frame.
  - Mid-frame input changes are ignored.
- States: IDLE -> START -> DATA -> (PARITY if latched PAR_EN) -> STOP -> IDLE, or STOP -> START when pop occurs in the last STOP cycle (back-to-back frames, no idle gap).
- Each of START, DATA (per bit), PARITY and STOP lasts exactly P=max(PRESCALE,1) cycles.
  - Timing is set by a prescale counter running 0..P-1.
  - The state or bit advances when the counter reaches P-1.
- TX_OUT and BUSY are registered.
  - If pop occurs at edge k, TX_OUT=0 and BUSY=1 from edge k+1.
  - START drives 0.
  - DATA drives shift[0]; the register shifts right on each bit boundary, and the bit counter runs 0..DATA_WIDTH-1.
  - PARITY drives (XOR of latched data) XOR PAR_TYP.
  - STOP drives 1.
  - BUSY returns to 0 on the edge that enters IDLE.
- Frame length:
  - P*(DATA_WIDTH+2) cycles without parity.
  - P*(DATA_WIDTH+3) cycles with parity.
- EMPTY timing: EMPTY reacts one or more cycles after a pop, which is always earlier than the next pop opportunity (at least DATA_WIDTH+2 cycles). No double pop is possible.
- TX_EN:
  - Deasserted mid-frame: the current frame completes; no further pop occurs.
  - Reasserted while in IDLE with EMPTY=0: pop on that cycle.
- EMPTY=1 in the last STOP cycle: go to IDLE, TX_OUT stays 1.
- Reset mid-frame:
  - Frame aborted immediately; TX_OUT=1.
  - The already-popped word is lost; no re-pop.
- R_INC is never asserted while EMPTY=1, while RST=0, or in START/DATA/PARITY.

Test Plan:
- Reset then idle: RST low with EMPTY=0 -> TX_OUT=1, BUSY=0, R_INC=0 throughout reset. After release with TX_EN=1 -> R_INC pulses for 1 cycle.
- Single frame without parity: PRESCALE=4, PAR_EN=0, RD_DATA=0xA5, EMPTY falls once -> one R_INC pulse. TX_OUT sequence (4 cycles per bit) is 0,1,0,1,0,0,1,0,1,1. BUSY is high for 40 cycles.
- Parity: PRESCALE=4, 0xA5. Even parity -> parity bit 0, odd parity -> 1, frame 44 cycles. With 0x01 and even parity -> parity bit 1.
- Back-to-back: FIFO holds 0x3C and 0xC3, PRESCALE=2 -> the second R_INC occurs in the last STOP cycle of frame 1. The START of frame 2 directly follows the stop bit with no gap. BUSY stays high 40 cycles continuously. Exactly two pops.
- TX_EN and PRESCALE changes: PRESCALE=0 -> 1 cycle per bit. TX_EN dropped mid-frame -> the frame finishes, then no pop although EMPTY=0. PRESCALE changed mid-frame -> current bit timing unchanged.
- Reset mid-frame: assert RST during DATA bit 3 -> TX_OUT=1 and BUSY=0 immediately (asynchronous). After release with EMPTY=0 -> new pop, and the next word is sent.
